// File: rtl/dmem_arbiter_pkg.sv
// Shared types and default geometry for the two-port data-memory arbiter.
package dmem_arbiter_pkg;

  localparam int DMEM_DW    = 8;
  localparam int DMEM_AW    = 3;
  localparam int DMEM_DEPTH = 1 << DMEM_AW;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DBG = 1'b1
  } req_e;

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Request/grant/read-data bundle between the two requesters and the memory arbiter.
interface dmem_arbiter_if
  import dmem_arbiter_pkg::*;
#(
  parameter int DW    = DMEM_DW,
  parameter int AW    = DMEM_AW,
  parameter int DEPTH = DMEM_DEPTH
);

  logic                cpu_req;
  logic                cpu_we;
  logic [AW-1:0]       cpu_addr;
  logic [DW-1:0]       cpu_wdata;
  logic                cpu_gnt;
  logic                cpu_rvalid;
  logic [DW-1:0]       cpu_rdata;

  logic                dbg_req;
  logic                dbg_we;
  logic [AW-1:0]       dbg_addr;
  logic [DW-1:0]       dbg_wdata;
  logic                dbg_lock;
  logic                dbg_gnt;
  logic                dbg_rvalid;
  logic [DW-1:0]       dbg_rdata;

  logic                locked;
  logic [DEPTH*DW-1:0] mem_flat;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  locked, mem_flat
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output locked, mem_flat
  );

endinterface

// File: rtl/dmem_rr_arb2.sv
// Two-way round-robin arbiter; while locked the debug port owns every grant.
module dmem_rr_arb2
  import dmem_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic cpu_req_i,
  input  logic dbg_req_i,
  input  logic lock_i,
  input  logic lock_exit_i,
  output logic cpu_gnt_o,
  output logic dbg_gnt_o,
  output req_e last_gnt_o
);

  req_e last_gnt_q;

  always_comb begin
    cpu_gnt_o = 1'b0;
    dbg_gnt_o = 1'b0;
    if (lock_i) begin
      dbg_gnt_o = dbg_req_i;
    end else if (cpu_req_i && dbg_req_i) begin
      if (last_gnt_q == REQ_DBG) cpu_gnt_o = 1'b1;
      else                       dbg_gnt_o = 1'b1;
    end else begin
      cpu_gnt_o = cpu_req_i;
      dbg_gnt_o = dbg_req_i;
    end
  end

  // Leaving LOCK hands priority to the CPU, which has been stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_gnt_q <= REQ_DBG;
    end else if (lock_exit_i || dbg_gnt_o) begin
      last_gnt_q <= REQ_DBG;
    end else if (cpu_gnt_o) begin
      last_gnt_q <= REQ_CPU;
    end
  end

  assign last_gnt_o = last_gnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// 8x8 data memory shared between the CPU and a debug/loader port, with debug lock.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DW    = DMEM_DW,
  parameter int AW    = DMEM_AW,
  parameter int DEPTH = DMEM_DEPTH
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  state_e        state_q;
  logic          locked_q;
  logic [DW-1:0] mem_q [DEPTH];
  logic          cpu_rvalid_q, dbg_rvalid_q;
  logic [DW-1:0] cpu_rdata_q, dbg_rdata_q;

  logic          cpu_gnt, dbg_gnt, lock_exit;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  req_e          last_gnt;

  assign lock_exit = (state_q == ST_LOCK) && !bus.dbg_lock;

  dmem_rr_arb2 u_arb (
    .clk         (clk),
    .rst         (rst),
    .cpu_req_i   (bus.cpu_req),
    .dbg_req_i   (bus.dbg_req),
    .lock_i      (state_q == ST_LOCK),
    .lock_exit_i (lock_exit),
    .cpu_gnt_o   (cpu_gnt),
    .dbg_gnt_o   (dbg_gnt),
    .last_gnt_o  (last_gnt)
  );

  // Grants are exclusive, so a single write port serves both requesters.
  always_comb begin
    wr_en   = (cpu_gnt && bus.cpu_we) || (dbg_gnt && bus.dbg_we);
    wr_addr = cpu_gnt ? bus.cpu_addr  : bus.dbg_addr;
    wr_data = cpu_gnt ? bus.cpu_wdata : bus.dbg_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_ARB;
      locked_q <= 1'b0;
    end else begin
      case (state_q)
        ST_ARB: begin
          if (dbg_gnt && bus.dbg_lock) begin
            state_q  <= ST_LOCK;
            locked_q <= 1'b1;
          end
        end
        ST_LOCK: begin
          if (!bus.dbg_lock) begin
            state_q  <= ST_ARB;
            locked_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= ST_ARB;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Writes from the previous edge are already in mem_q, giving read-after-write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      cpu_rvalid_q <= cpu_gnt && !bus.cpu_we;
      dbg_rvalid_q <= dbg_gnt && !bus.dbg_we;
      if (cpu_gnt && !bus.cpu_we) cpu_rdata_q <= mem_q[bus.cpu_addr];
      if (dbg_gnt && !bus.dbg_we) dbg_rdata_q <= mem_q[bus.dbg_addr];
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_flat
    assign bus.mem_flat[gi*DW +: DW] = mem_q[gi];
  end

  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.dbg_gnt    = dbg_gnt;
  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.dbg_rvalid = dbg_rvalid_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.dbg_rdata  = dbg_rdata_q;
  assign bus.locked     = locked_q;

  wire unused_last_gnt = (last_gnt == REQ_CPU);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed plan plus randomized traffic, checked against a transaction-level model.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_arbiter_if bus ();

  dmem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: memory contents, who was served last, lock ownership, read returns.
  logic [7:0] m_mem [8];
  bit         m_last_dbg;
  bit         m_lock;
  bit         m_crv, m_drv;
  logic [7:0] m_crd, m_drd;
  bit         e_cg, e_dg;
  bit         s_cg, s_dg;
  int         lock_run;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;
    m_last_dbg = 1'b1;
    m_lock     = 1'b0;
    m_crv      = 1'b0;
    m_drv      = 1'b0;
    m_crd      = 8'h00;
    m_drd      = 8'h00;
  endfunction

  function automatic void model_grants();
    if (m_lock) begin
      e_cg = 1'b0;
      e_dg = bus.dbg_req;
    end else if (bus.cpu_req && bus.dbg_req) begin
      e_cg = m_last_dbg;
      e_dg = !m_last_dbg;
    end else begin
      e_cg = bus.cpu_req;
      e_dg = bus.dbg_req;
    end
  endfunction

  function automatic void model_edge();
    m_crv = 1'b0;
    m_drv = 1'b0;
    if (e_cg) begin
      if (bus.cpu_we) m_mem[bus.cpu_addr] = bus.cpu_wdata;
      else begin m_crd = m_mem[bus.cpu_addr]; m_crv = 1'b1; end
      m_last_dbg = 1'b0;
    end
    if (e_dg) begin
      if (bus.dbg_we) m_mem[bus.dbg_addr] = bus.dbg_wdata;
      else begin m_drd = m_mem[bus.dbg_addr]; m_drv = 1'b1; end
      m_last_dbg = 1'b1;
    end
    if (m_lock) begin
      if (!bus.dbg_lock) begin
        m_lock     = 1'b0;
        m_last_dbg = 1'b1;
      end
    end else if (e_dg && bus.dbg_lock) begin
      m_lock = 1'b1;
    end
  endfunction

  function automatic logic [63:0] model_flat();
    logic [63:0] f;
    for (int i = 0; i < 8; i++) f[i*8 +: 8] = m_mem[i];
    return f;
  endfunction

  task automatic check_outputs();
    chk("cpu_rvalid", bus.cpu_rvalid, m_crv);
    chk("cpu_rdata",  bus.cpu_rdata,  m_crd);
    chk("dbg_rvalid", bus.dbg_rvalid, m_drv);
    chk("dbg_rdata",  bus.dbg_rdata,  m_drd);
    chk("locked",     bus.locked,     m_lock);
    chk("mem_flat",   bus.mem_flat,   model_flat());
  endtask

  // Inputs are set at the falling edge; grants are sampled mid-low, registers after the rise.
  task automatic tick();
    #1;
    model_grants();
    s_cg = bus.cpu_gnt;
    s_dg = bus.dbg_gnt;
    chk("cpu_gnt", s_cg, e_cg);
    chk("dbg_gnt", s_dg, e_dg);
    chk("gnt_excl", s_cg & s_dg, 1'b0);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
    $display("cyc t=%0t cg=%0b dg=%0b crv=%0b crd=%02h drv=%0b drd=%02h lk=%0b",
             $time, s_cg, s_dg, bus.cpu_rvalid, bus.cpu_rdata,
             bus.dbg_rvalid, bus.dbg_rdata, bus.locked);
  endtask

  task automatic set_cpu(bit req, bit we, int addr, int wd);
    bus.cpu_req   = req;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr[2:0];
    bus.cpu_wdata = wd[7:0];
  endtask

  task automatic set_dbg(bit req, bit we, int addr, int wd, bit lk);
    bus.dbg_req   = req;
    bus.dbg_we    = we;
    bus.dbg_addr  = addr[2:0];
    bus.dbg_wdata = wd[7:0];
    bus.dbg_lock  = lk;
  endtask

  initial begin
    rst = 1'b0;
    set_cpu(0, 0, 0, 0);
    set_dbg(0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    chk("rst_flat", bus.mem_flat, 64'h0);
    rst = 1'b1;

    // 1: debug write 0xA5 to addr 3
    set_dbg(1, 1, 3, 8'hA5, 0);
    tick();
    chk("t1_dbg_gnt", s_dg, 1'b1);
    chk("t1_byte3", bus.mem_flat[31:24], 8'hA5);
    chk("t1_others", bus.mem_flat & ~64'hFF00_0000, 64'h0);
    set_dbg(0, 0, 0, 0, 0);

    // 2: both requesters reading continuously must alternate CPU, DBG, CPU, DBG
    set_cpu(1, 0, 3, 0);
    set_dbg(1, 0, 3, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_cpu_gnt", s_cg, (i % 2) == 0);
      chk("t2_dbg_gnt", s_dg, (i % 2) == 1);
      if ((i % 2) == 0) begin
        chk("t2_cpu_rvalid", bus.cpu_rvalid, 1'b1);
        chk("t2_cpu_rdata", bus.cpu_rdata, 8'hA5);
        chk("t2_dbg_idle", bus.dbg_rvalid, 1'b0);
      end else begin
        chk("t2_dbg_rvalid", bus.dbg_rvalid, 1'b1);
        chk("t2_dbg_rdata", bus.dbg_rdata, 8'hA5);
        chk("t2_cpu_idle", bus.cpu_rvalid, 1'b0);
      end
    end
    set_cpu(0, 0, 0, 0);
    set_dbg(0, 0, 0, 0, 0);

    // 3: locked debug burst fills memory while the CPU waits
    for (int i = 0; i < 8; i++) begin
      set_dbg(1, 1, i, i + 1, i != 7);
      if (i >= 1) set_cpu(1, 0, 0, 0);
      tick();
      chk("t3_cpu_gnt", s_cg, 1'b0);
      chk("t3_locked", bus.locked, i != 7);
    end
    chk("t3_flat", bus.mem_flat, 64'h0807_0605_0403_0201);
    set_dbg(0, 0, 0, 0, 0);
    tick();
    chk("t3_cpu_after", s_cg, 1'b1);
    chk("t3_cpu_rdata", bus.cpu_rdata, 8'h01);
    set_cpu(0, 0, 0, 0);

    // 4: CPU read-after-write
    set_cpu(1, 1, 5, 8'h3C);
    tick();
    chk("t4_wr_gnt", s_cg, 1'b1);
    set_cpu(1, 0, 5, 0);
    tick();
    chk("t4_rvalid", bus.cpu_rvalid, 1'b1);
    chk("t4_rdata", bus.cpu_rdata, 8'h3C);
    set_cpu(0, 0, 0, 0);

    // 5: reset while locked with a debug read in flight
    set_dbg(1, 1, 2, 8'h55, 1);
    tick();
    chk("t5_locked", bus.locked, 1'b1);
    set_dbg(1, 0, 1, 0, 1);
    #1;
    chk("t5_dbg_gnt", bus.dbg_gnt, 1'b1);
    #1;
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    chk("t5_rvalid", bus.dbg_rvalid, 1'b0);
    chk("t5_locked_clr", bus.locked, 1'b0);
    chk("t5_flat", bus.mem_flat, 64'h0);
    check_outputs();
    set_cpu(0, 0, 0, 0);
    set_dbg(0, 0, 0, 0, 0);
    rst = 1'b1;
    set_cpu(1, 0, 2, 0);
    set_dbg(1, 0, 1, 0, 0);
    tick();
    chk("t5_cpu_first", s_cg, 1'b1);
    set_cpu(0, 0, 0, 0);
    set_dbg(0, 0, 0, 0, 0);
    s_cg = 1'b0;
    s_dg = 1'b0;

    // Random traffic: requests stay stable until granted, occasional lock bursts
    lock_run = 0;
    for (int n = 0; n < 400; n++) begin
      if (!bus.cpu_req || s_cg) begin
        if ($urandom_range(0, 9) < 7)
          set_cpu(1, 1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 255));
        else
          set_cpu(0, 0, 0, 0);
      end
      if (!bus.dbg_req || s_dg) begin
        if ($urandom_range(0, 9) < 6)
          set_dbg(1, 1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 255),
                  bus.dbg_lock);
        else
          set_dbg(0, 0, 0, 0, bus.dbg_lock);
      end
      if (lock_run > 0) begin
        lock_run--;
        bus.dbg_lock = 1'b1;
      end else if ($urandom_range(0, 19) == 0) begin
        lock_run = $urandom_range(2, 8);
        bus.dbg_lock = 1'b1;
      end else begin
        bus.dbg_lock = 1'b0;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
